// File: rtl/cmp_search_ctrl_pkg.sv
// Shared definitions for the signed-compare search controller.
//  - comparator result codes returned on cmp_code
//  - FSM state encoding used by cmp_search_ctrl
package cmp_pkg;

  localparam logic [1:0] CMP_EQ = 2'b01;  // A == B
  localparam logic [1:0] CMP_GT = 2'b10;  // A >  B (target above guess)
  localparam logic [1:0] CMP_LT = 2'b11;  // A <  B (target below guess)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_EVAL  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/cmp_search_ctrl_if.sv
// Handshake/bus bundle between the search controller and whoever starts it
// and supplies the comparator answer.
//  start     : request a new search
//  cmp_code  : comparator result for (A=target, B=guess)
//  guess     : value driven onto comparator B
//  busy/done/err, found_val, steps : search status and result
// slave  = the controller side, master = the requester/comparator side.
interface cmp_search_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                    start;
  logic [1:0]              cmp_code;
  logic signed [WIDTH-1:0] guess;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] found_val;
  logic [2:0]              steps;
  logic                    err;

  modport slave (
    input  start, cmp_code,
    output guess, busy, done, found_val, steps, err
  );

  modport master (
    output start, cmp_code,
    input  guess, busy, done, found_val, steps, err
  );
endinterface

// File: rtl/cmp_search_ctrl_settle_cnt.sv
// cmp_settle_cnt: down-counter that holds a guess steady before the
// comparator answer is trusted.
//  clk, rst  : clock, synchronous active-high reset
//  load      : load load_val (takes priority over counting)
//  load_val  : number of extra cycles to wait
//  expired   : counter is at zero
module cmp_settle_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt_r;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/cmp_search_ctrl.sv
// cmp_search_ctrl: initiator of the signed compare interface. Drives guesses
// on comparator B, reads back the code and binary-searches the signed target
// on comparator A, then reports the value and the number of probes.
//  clk, rst : clock, synchronous active-high reset
//  bus      : cmp_search_ctrl_if.slave (start, cmp_code in; guess, busy,
//             done, found_val, steps, err out; all outputs registered)
module cmp_search_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  cmp_search_ctrl_if.slave   bus
);

  localparam int CW = $clog2(SETTLE + 1);
  // The first probe gets one extra hold cycle so the freshly launched guess
  // settles after the window set-up; later probes hold exactly SETTLE cycles.
  localparam logic [CW-1:0] LOAD_FIRST = CW'(SETTLE);
  localparam logic [CW-1:0] LOAD_NEXT  = CW'(SETTLE - 1);

  localparam logic signed [WIDTH:0] LO_INIT = {2'b11, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0] HI_INIT = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] ONE_W   = {{WIDTH{1'b0}}, 1'b1};

  // floor((lo+hi)/2) in WIDTH+1 bits; the result always lies in [lo,hi],
  // which is inside the WIDTH-bit signed range, so truncation is lossless.
  function automatic logic signed [WIDTH-1:0] win_mid(
    input logic signed [WIDTH:0] lo,
    input logic signed [WIDTH:0] hi
  );
    logic signed [WIDTH:0] sum;
    sum = lo + hi;
    return WIDTH'(sum >>> 1);
  endfunction

  state_t                  state_r;
  logic signed [WIDTH:0]   lo_r, hi_r;
  logic signed [WIDTH-1:0] guess_r, found_r;
  logic                    busy_r, done_r, err_r;
  logic [2:0]              steps_r;

  logic signed [WIDTH:0]   guess_ext_s, new_lo_s, new_hi_s;
  logic signed [WIDTH-1:0] next_mid_s, init_mid_s;
  logic                    cross_s, start_ok_s, narrow_s, load_s, expired_s;
  logic [CW-1:0]           load_val_s;

  assign init_mid_s = win_mid(LO_INIT, HI_INIT);

  // Window update implied by the current comparator answer.
  always_comb begin
    guess_ext_s = {guess_r[WIDTH-1], guess_r};
    new_lo_s    = lo_r;
    new_hi_s    = hi_r;
    narrow_s    = 1'b0;
    case (bus.cmp_code)
      CMP_GT: begin
        new_lo_s = guess_ext_s + ONE_W;
        narrow_s = 1'b1;
      end
      CMP_LT: begin
        new_hi_s = guess_ext_s - ONE_W;
        narrow_s = 1'b1;
      end
      default: begin
        new_lo_s = lo_r;
        new_hi_s = hi_r;
        narrow_s = 1'b0;
      end
    endcase
    cross_s    = (new_lo_s > new_hi_s);
    next_mid_s = win_mid(new_lo_s, new_hi_s);
  end

  // Start acceptance and settle-counter load control.
  always_comb begin
    start_ok_s = bus.start &&
                 ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    if (start_ok_s) begin
      load_s     = 1'b1;
      load_val_s = LOAD_FIRST;
    end else if ((state_r == ST_EVAL) && narrow_s && !cross_s) begin
      load_s     = 1'b1;
      load_val_s = LOAD_NEXT;
    end else begin
      load_s     = 1'b0;
      load_val_s = LOAD_NEXT;
    end
  end

  cmp_settle_cnt #(.CW(CW)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .expired  (expired_s)
  );

  // Search FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      lo_r    <= {(WIDTH+1){1'b0}};
      hi_r    <= {(WIDTH+1){1'b0}};
      guess_r <= {WIDTH{1'b0}};
      found_r <= {WIDTH{1'b0}};
      steps_r <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          done_r <= 1'b0;
          if (start_ok_s) begin
            lo_r    <= LO_INIT;
            hi_r    <= HI_INIT;
            guess_r <= init_mid_s;
            steps_r <= 3'd1;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_PROBE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_PROBE: begin
          if (expired_s) begin
            state_r <= ST_EVAL;
          end else begin
            state_r <= ST_PROBE;
          end
        end
        ST_EVAL: begin
          case (bus.cmp_code)
            CMP_EQ: begin
              found_r <= guess_r;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_DONE;
            end
            CMP_GT, CMP_LT: begin
              lo_r <= new_lo_s;
              hi_r <= new_hi_s;
              if (cross_s) begin
                // Answers contradict each other: the window emptied.
                err_r   <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= ST_ERR;
              end else begin
                guess_r <= next_mid_s;
                steps_r <= steps_r + 3'd1;
                state_r <= ST_PROBE;
              end
            end
            default: begin
              err_r   <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_ERR;
            end
          endcase
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.guess     = guess_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.found_val = found_r;
  assign bus.steps     = steps_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl: two instances (SETTLE=1 and SETTLE=3)
// each talking to a behavioural 4-bit signed comparator with A=target.
module tb_cmp_search_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              tb_start;
  logic              force_en;
  logic [1:0]        force_code;
  logic signed [3:0] target;
  bit                sel;  // 0: SETTLE=1 instance, 1: SETTLE=3 instance

  int checks = 0;
  int errors = 0;

  cmp_search_ctrl_if #(.WIDTH(4)) bus1 ();
  cmp_search_ctrl_if #(.WIDTH(4)) bus3 ();

  cmp_search_ctrl #(.WIDTH(4), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cmp_search_ctrl #(.WIDTH(4), .SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Behavioural signed comparator: 01 A==B, 10 A>B, 11 A<B.
  function automatic logic [1:0] cmp_fn(input logic signed [3:0] a, input logic signed [3:0] b);
    if (a == b)     return 2'b01;
    else if (a > b) return 2'b10;
    else            return 2'b11;
  endfunction

  assign bus1.start    = tb_start & ~sel;
  assign bus3.start    = tb_start & sel;
  assign bus1.cmp_code = force_en ? force_code : cmp_fn(target, bus1.guess);
  assign bus3.cmp_code = force_en ? force_code : cmp_fn(target, bus3.guess);

  logic signed [3:0] cur_guess, cur_found;
  logic              cur_busy, cur_done, cur_err;
  logic [2:0]        cur_steps;
  assign cur_guess = sel ? bus3.guess     : bus1.guess;
  assign cur_found = sel ? bus3.found_val : bus1.found_val;
  assign cur_busy  = sel ? bus3.busy      : bus1.busy;
  assign cur_done  = sel ? bus3.done      : bus1.done;
  assign cur_err   = sel ? bus3.err       : bus1.err;
  assign cur_steps = sel ? bus3.steps     : bus1.steps;

  int  g_q[$];
  bit  done_seen, err_seen, overlap, timed_out, err_at_start;
  int  done_cyc;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Probe count of an ideal floor-mid binary search over [-8,7].
  function automatic int model_probes(input int tgt);
    int lo, hi, mid, n;
    lo = -8; hi = 7; n = 0;
    for (int k = 0; k < 8; k++) begin
      n++;
      mid = (lo + hi) >>> 1;
      if (mid == tgt) break;
      else if (tgt > mid) lo = mid + 1;
      else hi = mid - 1;
    end
    return n;
  endfunction

  task automatic run_search(input logic signed [3:0] tgt, input bit extra);
    logic signed [3:0] last;
    g_q.delete();
    target    = tgt;
    done_seen = 1'b0;
    err_seen  = 1'b0;
    overlap   = 1'b0;
    timed_out = 1'b1;
    done_cyc  = -1;
    @(negedge clk);
    tb_start = 1'b1;
    @(posedge clk);
    #1;
    tb_start     = 1'b0;
    err_at_start = cur_err;
    last         = cur_guess;
    g_q.push_back(int'(cur_guess));
    for (int i = 1; i <= 80; i++) begin
      if (extra) tb_start = (i == 2) || (i == 4);
      @(posedge clk);
      #1;
      if (cur_guess !== last) begin
        g_q.push_back(int'(cur_guess));
        last = cur_guess;
      end
      if (cur_busy && cur_done) overlap = 1'b1;
      if (cur_done) begin
        done_seen = 1'b1; done_cyc = i; timed_out = 1'b0;
        break;
      end
      if (cur_err) begin
        err_seen = 1'b1; timed_out = 1'b0;
        break;
      end
    end
    tb_start = 1'b0;
    check("timeout", timed_out, 0);
  endtask

  task automatic check_guesses(input string tag, input int n,
                               input int e0, input int e1, input int e2, input int e3, input int e4);
    int e[5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    check({tag, "_count"}, g_q.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < g_q.size()) check({tag, "_g"}, g_q[k], e[k]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit late_done;
    rst = 1'b1; tb_start = 1'b0; force_en = 1'b0; force_code = 2'b00;
    target = 4'sd0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, both instances
    check("rst_guess1", bus1.guess, 0);
    check("rst_busy1",  bus1.busy, 0);
    check("rst_done1",  bus1.done, 0);
    check("rst_found1", bus1.found_val, 0);
    check("rst_steps1", bus1.steps, 0);
    check("rst_err1",   bus1.err, 0);
    check("rst_busy3",  bus3.busy, 0);
    check("rst_steps3", bus3.steps, 0);
    @(negedge clk);
    rst = 1'b0;

    // Target 5: guesses -1,3,5; done 3*2+1 cycles after start
    run_search(4'sd5, 1'b0);
    check_guesses("t5", 3, -1, 3, 5, 0, 0);
    check("t5_done",  done_seen, 1);
    check("t5_cyc",   done_cyc, 7);
    check("t5_found", cur_found, 5);
    check("t5_steps", cur_steps, 3);
    check("t5_busy",  cur_busy, 0);

    // Target -8: guesses -1,-5,-7,-8
    run_search(-4'sd8, 1'b0);
    check_guesses("tm8", 4, -1, -5, -7, -8, 0);
    check("tm8_found", cur_found, -8);
    check("tm8_steps", cur_steps, 4);
    check("tm8_cyc",   done_cyc, 9);

    // Target 7: worst case, five probes
    run_search(4'sd7, 1'b0);
    check_guesses("t7", 5, -1, 3, 5, 6, 7);
    check("t7_found", cur_found, 7);
    check("t7_steps", cur_steps, 5);
    check("t7_cyc",   done_cyc, 11);

    // Extra start pulses while busy are ignored
    run_search(4'sd5, 1'b1);
    check_guesses("xs", 3, -1, 3, 5, 0, 0);
    check("xs_cyc",   done_cyc, 7);
    check("xs_steps", cur_steps, 3);
    check("xs_found", cur_found, 5);

    // Start in the first DONE cycle (done still high) is accepted
    tb_start = 1'b1;
    @(posedge clk);
    #1;
    tb_start = 1'b0;
    check("sd_busy",  cur_busy, 1);
    check("sd_done",  cur_done, 0);
    check("sd_guess", cur_guess, -1);
    check("sd_steps", cur_steps, 1);
    repeat (12) @(posedge clk);
    #1;
    check("sd_idle",  cur_busy, 0);

    // Illegal code 00 in the first EVAL -> ERR, no done
    force_en = 1'b1; force_code = 2'b00;
    run_search(4'sd3, 1'b0);
    check("ill_err",   err_seen, 1);
    check("ill_done",  done_seen, 0);
    check("ill_steps", cur_steps, 1);
    check("ill_busy",  cur_busy, 0);
    force_en = 1'b0;

    // Comparator reconnected, target 2: err clears on start
    run_search(4'sd2, 1'b0);
    check("rc_errclr", err_at_start, 0);
    check("rc_found",  cur_found, 2);
    check("rc_steps",  cur_steps, 4);
    check("rc_err",    cur_err, 0);

    // Lying responder (always 10): guesses -1,3,5,6,7, window empties after the 5th
    force_en = 1'b1; force_code = 2'b10;
    run_search(4'sd0, 1'b0);
    check_guesses("lie", 5, -1, 3, 5, 6, 7);
    check("lie_err",   err_seen, 1);
    check("lie_done",  done_seen, 0);
    check("lie_steps", cur_steps, 5);
    check("lie_found", cur_found, 2);
    force_en = 1'b0;

    // Sweep all targets on both SETTLE values
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int t = -8; t <= 7; t++) begin
        run_search(4'(t), 1'b0);
        check("sw_found", cur_found, t);
        check("sw_steps", cur_steps, model_probes(t));
        check("sw_cyc",   done_cyc, model_probes(t) * (s == 1 ? 4 : 2) + 1);
        check("sw_ovl",   overlap, 0);
      end
    end
    sel = 1'b0;

    // rst during the second PROBE aborts everything
    target = 4'sd5;
    @(negedge clk);
    tb_start = 1'b1;
    @(posedge clk);
    #1;
    tb_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ar_busy_pre", cur_busy, 1);
    check("ar_guess_pre", cur_guess, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("ar_guess", cur_guess, 0);
    check("ar_busy",  cur_busy, 0);
    check("ar_done",  cur_done, 0);
    check("ar_found", cur_found, 0);
    check("ar_steps", cur_steps, 0);
    check("ar_err",   cur_err, 0);
    late_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (cur_done || cur_err || cur_busy) late_done = 1'b1;
    end
    check("ar_quiet", late_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
